dram_bridge: RTL and testbench

// - Data-side responder for the pipelined CPU's data port: decodes dram_addr, returns read data, commits writes.
// - Holds the data RAM plus memory-mapped LED, switch, 7-segment and timer peripherals.
// - Read data is combinational, so the CPU captures it in the same MEM cycle.
// - Writes commit on the rising clock edge, ending that MEM cycle.

---
 rtl/dram_bridge.sv | 140 ++++++++++++++
 tb/tb_dram_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_bridge.sv
// Data-port responder for the CPU: data RAM plus LED, switch, 7-segment and timer peripherals.
// Define DRAM_BRIDGE_TIMER_EN to include the free-running timer at 0xFFFF_F020.
module dram_bridge #(
  parameter int RAM_AW   = 12,
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dram_addr_i,
  input  logic [31:0] dram_wdata_i,
  input  logic        dram_we_i,
  output logic [31:0] dram_rdata_o,
  input  logic [23:0] sw_i,
  output logic [23:0] led_o,
  output logic [7:0]  seg_en_o,
  output logic [7:0]  seg_o
);

  localparam logic [31:0] ADDR_DISP  = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
  localparam logic [19:0] SCAN_LAST  = 20'(SCAN_DIV - 1);

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  logic [31:0]       ram_q [0:(1<<RAM_AW)-1];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit;
  logic              ram_we;

  logic [31:0] display_q, display_d;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_meta_q, sw_meta_d;
  logic [23:0] sw_sync_q, sw_sync_d;
  logic [19:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  seg_en_q, seg_en_d;
  logic [7:0]  seg_q, seg_d;

`ifdef DRAM_BRIDGE_TIMER_EN
  logic [31:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (dram_we_i && dram_addr_i == ADDR_TIMER) timer_d = dram_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) timer_q <= '0;
    else          timer_q <= timer_d;
  end
`endif

  always_comb begin
    ram_idx   = dram_addr_i[RAM_AW+1:2];
    ram_hit   = (dram_addr_i[31:RAM_AW+2] == '0);
    ram_we    = dram_we_i && ram_hit;

    display_d = display_q;
    led_d     = led_q;
    if (dram_we_i && dram_addr_i == ADDR_DISP) display_d = dram_wdata_i;
    if (dram_we_i && dram_addr_i == ADDR_LED)  led_d     = dram_wdata_i[23:0];

    sw_meta_d = sw_i;
    sw_sync_d = sw_meta_q;

    // The digit refresh samples the display register as it stood before this edge.
    scan_cnt_d = scan_cnt_q + 20'd1;
    idx_d      = idx_q;
    seg_en_d   = seg_en_q;
    seg_d      = seg_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
      seg_en_d   = ~(8'b1 << idx_d);
      seg_d      = hex7(display_q[{idx_d, 2'b00} +: 4]);
    end

    dram_rdata_o = '0;
    if (dram_addr_i == ADDR_DISP)       dram_rdata_o = display_q;
`ifdef DRAM_BRIDGE_TIMER_EN
    else if (dram_addr_i == ADDR_TIMER) dram_rdata_o = timer_q;
`endif
    else if (dram_addr_i == ADDR_LED)   dram_rdata_o = {8'h00, led_q};
    else if (dram_addr_i == ADDR_SW)    dram_rdata_o = {8'h00, sw_sync_q};
    else if (ram_hit)                   dram_rdata_o = ram_q[ram_idx];
  end

  // RAM keeps its contents through reset; only the write is suppressed while reset is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (rst_n_i && ram_we) ram_q[ram_idx] <= dram_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      display_q  <= '0;
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      scan_cnt_q <= '0;
      idx_q      <= 3'd7;
      seg_en_q   <= 8'hFF;
      seg_q      <= 8'hFF;
    end else begin
      display_q  <= display_d;
      led_q      <= led_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_en_q   <= seg_en_d;
      seg_q      <= seg_d;
    end
  end

  assign led_o    = led_q;
  assign seg_en_o = seg_en_q;
  assign seg_o    = seg_q;

endmodule

// File: tb/tb_dram_bridge.sv
// Directed bench for dram_bridge: a behavioural model checked every cycle plus literal expectations.
module tb_dram_bridge;

  localparam int SD = 4;
  localparam logic [31:0] A_DISP = 32'hFFFF_F000;
  localparam logic [31:0] A_TMR  = 32'hFFFF_F020;
  localparam logic [31:0] A_LED  = 32'hFFFF_F060;
  localparam logic [31:0] A_SW   = 32'hFFFF_F070;
`ifdef DRAM_BRIDGE_TIMER_EN
  localparam bit TMR_ON = 1'b1;
`else
  localparam bit TMR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [31:0] addr  = A_DISP;
  logic [31:0] wdata = '0;
  logic        we    = 1'b0;
  logic [23:0] sw    = '0;
  logic [31:0] rdata;
  logic [23:0] led;
  logic [7:0]  seg_en, seg;

  dram_bridge #(.RAM_AW(12), .SCAN_DIV(SD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .dram_addr_i(addr), .dram_wdata_i(wdata),
    .dram_we_i(we), .dram_rdata_o(rdata), .sw_i(sw), .led_o(led),
    .seg_en_o(seg_en), .seg_o(seg)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as the programmer sees it, updated once per clock edge.
  logic [7:0]  GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [31:0] m_ram [int];
  logic [31:0] m_disp, m_tmr, old_disp;
  logic [23:0] m_led, m_s1, m_s2;
  logic [7:0]  m_en, m_seg;
  int          m_cyc, digit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_disp = '0; m_tmr = '0; m_led = '0; m_s1 = '0; m_s2 = '0;
      m_en = 8'hFF; m_seg = 8'hFF; m_cyc = 0;
    end else begin
      old_disp = m_disp;
      m_cyc++;
      if (m_cyc % SD == 0) begin
        digit = (m_cyc / SD - 1) % 8;
        m_en  = ~(8'b1 << digit);
        m_seg = GLYPH[int'((old_disp >> (4 * digit)) & 32'hF)];
      end
      if (TMR_ON) m_tmr = m_tmr + 32'd1;
      if (we) begin
        if (addr == A_DISP)                m_disp = wdata;
        else if (addr == A_TMR && TMR_ON)  m_tmr  = wdata;
        else if (addr == A_LED)            m_led  = wdata[23:0];
        else if (addr < 32'h0000_4000)     m_ram[int'(addr >> 2)] = wdata;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  task automatic exp_rd(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v = '0;
    if (a == A_DISP)                  v = m_disp;
    else if (a == A_TMR)              v = TMR_ON ? m_tmr : 32'd0;
    else if (a == A_LED)              v = {8'h00, m_led};
    else if (a == A_SW)               v = {8'h00, m_s2};
    else if (a < 32'h0000_4000) begin
      if (m_ram.exists(int'(a >> 2))) v = m_ram[int'(a >> 2)];
      else known = 1'b0;
    end
  endtask

  logic [31:0] cmp_v;
  bit          cmp_known;
  always begin
    @(negedge clk);
    #3;
    if (armed) begin
      chk("led_model", {8'h00, led}, {8'h00, m_led});
      chk("seg_en_model", {24'h0, seg_en}, {24'h0, m_en});
      chk("seg_model", {24'h0, seg}, {24'h0, m_seg});
      exp_rd(addr, cmp_v, cmp_known);
      if (cmp_known) chk("rdata_model", rdata, cmp_v);
    end
  end

  // One bus cycle: inputs change at the falling edge, results observed 2 units later.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(negedge clk);
    addr = a; wdata = d; we = w;
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_led", {8'h00, led}, 32'h0);
    chk("rst_seg_en", {24'h0, seg_en}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    chk("rst_disp_rd", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b1;

    for (int k = 1; k <= 10; k++) cyc(A_TMR, 32'h0, 1'b0);
    chk("timer_10", rdata, TMR_ON ? 32'd10 : 32'd0);
    cyc(A_TMR, 32'hFFFF_FFFE, 1'b1);
    chk("timer_wr_old", rdata, TMR_ON ? 32'd11 : 32'd0);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("timer_load", rdata, TMR_ON ? 32'hFFFF_FFFE : 32'd0);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("timer_max", rdata, TMR_ON ? 32'hFFFF_FFFF : 32'd0);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("timer_wrap", rdata, 32'd0);

    cyc(32'h10, 32'h1111_1111, 1'b1);
    cyc(32'h10, 32'h1234_5678, 1'b1);
    chk("ram_old_during_wr", rdata, 32'h1111_1111);
    cyc(32'h10, 32'h0, 1'b0);
    chk("ram_rd_10", rdata, 32'h1234_5678);
    cyc(32'h13, 32'h0, 1'b0);
    chk("ram_rd_13", rdata, 32'h1234_5678);

    cyc(A_LED, 32'hABCD_EF01, 1'b1);
    cyc(A_LED, 32'h0, 1'b0);
    chk("led_out", {8'h00, led}, 32'h00CD_EF01);
    chk("led_rd", rdata, 32'h00CD_EF01);
    cyc(A_SW, 32'hFFFF_FFFF, 1'b1);
    cyc(A_SW, 32'h0, 1'b0);
    chk("sw_wr_led", {8'h00, led}, 32'h00CD_EF01);
    chk("sw_wr_rd", rdata, 32'h0);

    sw = 24'h00A5A5;
    cyc(A_SW, 32'h0, 1'b0);
    chk("sw_1edge", rdata, 32'h0);
    cyc(A_SW, 32'h0, 1'b0);
    chk("sw_2edge", rdata, 32'h0000_A5A5);

    cyc(32'h8000_0000, 32'hDEAD_BEEF, 1'b1);
    chk("unmapped_rd_wr", rdata, 32'h0);
    cyc(32'h8000_0000, 32'h0, 1'b0);
    chk("unmapped_rd", rdata, 32'h0);
    cyc(32'h10, 32'h0, 1'b0);
    chk("ram_after_unmapped", rdata, 32'h1234_5678);

    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_led", {8'h00, led}, 32'h0);
    chk("midrst_seg_en", {24'h0, seg_en}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(32'h10, 32'h0, 1'b0);
    chk("ram_survives_rst", rdata, 32'h1234_5678);
    cyc(A_DISP, 32'h8765_43F0, 1'b1);
    chk("disp_wr_old", rdata, 32'h0);
    for (int k = 3; k <= 40; k++) begin
      cyc(A_DISP, 32'h0, 1'b0);
      if (k == 3) begin
        chk("seg_en_pre", {24'h0, seg_en}, 32'hFF);
        chk("seg_pre", {24'h0, seg}, 32'hFF);
      end
      if (k == 4 || k == 36) begin
        chk("seg_en_d0", {24'h0, seg_en}, 32'hFE);
        chk("seg_d0", {24'h0, seg}, 32'hC0);
      end
      if (k == 8) begin
        chk("seg_en_d1", {24'h0, seg_en}, 32'hFD);
        chk("seg_d1", {24'h0, seg}, 32'h8E);
      end
      if (k == 32) begin
        chk("seg_en_d7", {24'h0, seg_en}, 32'h7F);
        chk("seg_d7", {24'h0, seg}, 32'h80);
      end
    end
    chk("disp_rd", rdata, 32'h8765_43F0);

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
